// File: rtl/uart_bus_initiator_if.sv
// Signal bundle between uart_bus_initiator and its surroundings: user byte streams,
// configuration request and the CPU-side register strobes of the UART block.
interface uart_bus_initiator_if #(
  parameter int CPU_ADDR_WIDTH  = 2,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int MAX_UART_DATA_W = 8
);
  logic [CPU_DATA_WIDTH-1:0]  cfg_ctrl_i;
  logic                       cfg_valid_i;
  logic [MAX_UART_DATA_W-1:0] tx_data_i;
  logic                       tx_valid_i;
  logic                       tx_ready_o;
  logic [MAX_UART_DATA_W-1:0] rx_data_o;
  logic [1:0]                 rx_err_o;
  logic                       rx_valid_o;
  logic                       rx_ready_i;
  logic                       busy_o;
  logic                       wr_en_cpu_o;
  logic                       rd_en_cpu_o;
  logic [CPU_ADDR_WIDTH-1:0]  cpu_addr_o;
  logic [CPU_DATA_WIDTH-1:0]  cpu_data_o;
  logic [CPU_DATA_WIDTH-1:0]  cpu_data_i;

  modport master (
    input  cfg_ctrl_i, cfg_valid_i, tx_data_i, tx_valid_i, rx_ready_i, cpu_data_i,
    output tx_ready_o, rx_data_o, rx_err_o, rx_valid_o, busy_o,
           wr_en_cpu_o, rd_en_cpu_o, cpu_addr_o, cpu_data_o
  );

  modport slave (
    output cfg_ctrl_i, cfg_valid_i, tx_data_i, tx_valid_i, rx_ready_i, cpu_data_i,
    input  tx_ready_o, rx_data_o, rx_err_o, rx_valid_o, busy_o,
           wr_en_cpu_o, rd_en_cpu_o, cpu_addr_o, cpu_data_o
  );
endinterface

// File: rtl/uart_bus_initiator.sv
// CPU-less register sequencer for the UART block: CTRL/TX writes, STAT polling, RX reads.
// Tx byte reaches the TX write 2 cycles after accept; one-byte buffers each way, rx held until consumed.
module uart_bus_initiator #(
  parameter int CPU_ADDR_WIDTH  = 2,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int MAX_UART_DATA_W = 8,
  parameter int POLL_GAP        = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  uart_bus_initiator_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_CFG   = 3'd1;
  localparam logic [2:0] S_WR_TXD   = 3'd2;
  localparam logic [2:0] S_WR_START = 3'd3;
  localparam logic [2:0] S_POLL_RD  = 3'd4;
  localparam logic [2:0] S_POLL_CHK = 3'd5;
  localparam logic [2:0] S_RX_RD    = 3'd6;
  localparam logic [2:0] S_RX_CHK   = 3'd7;

  localparam logic [CPU_ADDR_WIDTH-1:0] A_STAT = CPU_ADDR_WIDTH'(0);
  localparam logic [CPU_ADDR_WIDTH-1:0] A_CTRL = CPU_ADDR_WIDTH'(1);
  localparam logic [CPU_ADDR_WIDTH-1:0] A_TX   = CPU_ADDR_WIDTH'(2);
  localparam logic [CPU_ADDR_WIDTH-1:0] A_RX   = CPU_ADDR_WIDTH'(3);

  localparam logic [CPU_DATA_WIDTH-1:0] START_MASK = CPU_DATA_WIDTH'(2);

  localparam int                 GAP_W      = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(POLL_GAP);

  logic [2:0]                 state, state_nxt;
  logic                       cfg_pend;
  logic [CPU_DATA_WIDTH-1:0]  cfg_word;
  logic [CPU_DATA_WIDTH-1:0]  ctrl_shadow;
  logic [MAX_UART_DATA_W-1:0] tx_buf;
  logic                       tx_full;
  logic                       tx_inflight;
  logic                       tx_seen;
  logic [MAX_UART_DATA_W-1:0] rx_buf;
  logic [1:0]                 rx_err;
  logic [1:0]                 rx_err_pend;
  logic                       rx_full;
  logic [GAP_W-1:0]           gap_cnt;

  logic tx_accept, rx_pop;
  logic stat_tx_done, stat_tx_busy, stat_rx_done, stat_par_err, stat_stop_err;
  logic unused_rd_bits;

  assign tx_accept     = bus.tx_valid_i && !tx_full;
  assign rx_pop        = rx_full && bus.rx_ready_i;
  assign stat_tx_done  = bus.cpu_data_i[0];
  assign stat_tx_busy  = bus.cpu_data_i[1];
  assign stat_rx_done  = bus.cpu_data_i[16];
  assign stat_par_err  = bus.cpu_data_i[18];
  assign stat_stop_err = bus.cpu_data_i[19];
  assign unused_rd_bits = ^bus.cpu_data_i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfg_pend)                      state_nxt = S_WR_CFG;
        else if (tx_full && !tx_inflight)  state_nxt = S_WR_TXD;
        else if (gap_cnt <= GAP_W'(1))     state_nxt = S_POLL_RD;
      end
      S_WR_CFG:   state_nxt = S_IDLE;
      S_WR_TXD:   state_nxt = S_WR_START;
      S_WR_START: state_nxt = S_IDLE;
      S_POLL_RD:  state_nxt = S_POLL_CHK;
      // A held rx byte masks rx_done so the register side keeps it until we have room.
      S_POLL_CHK: state_nxt = (stat_rx_done && !rx_full) ? S_RX_RD : S_IDLE;
      S_RX_RD:    state_nxt = S_RX_CHK;
      S_RX_CHK:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    bus.wr_en_cpu_o = 1'b0;
    bus.rd_en_cpu_o = 1'b0;
    bus.cpu_addr_o  = '0;
    bus.cpu_data_o  = '0;
    case (state)
      S_WR_CFG: begin
        bus.wr_en_cpu_o = 1'b1;
        bus.cpu_addr_o  = A_CTRL;
        bus.cpu_data_o  = cfg_word;
      end
      S_WR_TXD: begin
        bus.wr_en_cpu_o = 1'b1;
        bus.cpu_addr_o  = A_TX;
        bus.cpu_data_o  = {{(CPU_DATA_WIDTH-MAX_UART_DATA_W){1'b0}}, tx_buf};
      end
      S_WR_START: begin
        bus.wr_en_cpu_o = 1'b1;
        bus.cpu_addr_o  = A_CTRL;
        bus.cpu_data_o  = ctrl_shadow | START_MASK;
      end
      S_POLL_RD: begin
        bus.rd_en_cpu_o = 1'b1;
        bus.cpu_addr_o  = A_STAT;
      end
      S_RX_RD: begin
        bus.rd_en_cpu_o = 1'b1;
        bus.cpu_addr_o  = A_RX;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cfg_pend    <= 1'b0;
      cfg_word    <= '0;
      ctrl_shadow <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_inflight <= 1'b0;
      tx_seen     <= 1'b0;
      rx_buf      <= '0;
      rx_err      <= '0;
      rx_err_pend <= '0;
      rx_full     <= 1'b0;
      gap_cnt     <= GAP_RELOAD;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
      if ((state == S_POLL_CHK && state_nxt == S_IDLE) || state == S_RX_CHK)
        gap_cnt <= GAP_RELOAD;

      if (state == S_WR_CFG) begin
        ctrl_shadow <= cfg_word;
        cfg_pend    <= 1'b0;
      end
      // A request arriving during WR_CFG wins and is written on the next pass.
      if (bus.cfg_valid_i) begin
        cfg_pend <= 1'b1;
        cfg_word <= bus.cfg_ctrl_i & ~START_MASK;
      end

      if (tx_accept) begin
        tx_buf  <= bus.tx_data_i;
        tx_full <= 1'b1;
      end
      if (state == S_WR_START) begin
        tx_full     <= 1'b0;
        tx_inflight <= 1'b1;
        tx_seen     <= 1'b0;
      end

      // tx_done may be missed between polls, so busy seen high then low also ends the transfer.
      if (state == S_POLL_CHK && tx_inflight) begin
        if (stat_tx_done || (tx_seen && !stat_tx_busy))
          tx_inflight <= 1'b0;
        else if (stat_tx_busy)
          tx_seen <= 1'b1;
      end

      if (state == S_POLL_CHK && state_nxt == S_RX_RD)
        rx_err_pend <= {stat_stop_err, stat_par_err};

      if (rx_pop)
        rx_full <= 1'b0;
      if (state == S_RX_CHK) begin
        rx_buf  <= bus.cpu_data_i[MAX_UART_DATA_W-1:0];
        rx_err  <= rx_err_pend;
        rx_full <= 1'b1;
      end
    end
  end

  assign bus.tx_ready_o = !tx_full;
  assign bus.rx_data_o  = rx_buf;
  assign bus.rx_err_o   = rx_err;
  assign bus.rx_valid_o = rx_full;
  assign bus.busy_o     = (state != S_IDLE) || tx_inflight;

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator with a small register-side responder model.
module tb_uart_bus_initiator;
  localparam int POLL_GAP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_bus_initiator_if #(.CPU_ADDR_WIDTH(2), .CPU_DATA_WIDTH(32), .MAX_UART_DATA_W(8)) bus ();

  uart_bus_initiator #(
    .CPU_ADDR_WIDTH(2), .CPU_DATA_WIDTH(32), .MAX_UART_DATA_W(8), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int junk = 0;
  int rx_reads = 0;
  logic [31:0] stat_val = 32'h0;
  logic [31:0] rx_val = 32'h0;
  logic        cap_rd = 1'b0;
  logic [31:0] cap_val = 32'h0;

  // Register side: read data appears in the cycle after the read strobe.
  always @(posedge clk) begin
    cap_rd  <= bus.rd_en_cpu_o;
    cap_val <= (bus.cpu_addr_o == 2'd0) ? stat_val :
               (bus.cpu_addr_o == 2'd3) ? rx_val : 32'h0;
    if (bus.wr_en_cpu_o && bus.rd_en_cpu_o) overlap <= overlap + 1;
    if (bus.rd_en_cpu_o && bus.cpu_addr_o == 2'd3) rx_reads <= rx_reads + 1;
    if (!bus.wr_en_cpu_o && !bus.rd_en_cpu_o && (bus.cpu_addr_o != 2'd0 || bus.cpu_data_o != 32'h0))
      junk <= junk + 1;
  end
  always @(negedge clk) bus.cpu_data_i <= cap_rd ? cap_val : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input bit want_wr, input string tag,
                             output logic [1:0] addr, output logic [31:0] data, output int waited);
    waited = 0;
    addr = 2'd0;
    data = 32'h0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (want_wr ? bus.wr_en_cpu_o : bus.rd_en_cpu_o) begin
        waited = i;
        addr = bus.cpu_addr_o;
        data = bus.cpu_data_o;
        break;
      end
    end
    checks++;
    assert (waited != 0) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=strobe", tag);
    end
  endtask

  logic [1:0]  a;
  logic [31:0] d;
  int          w;
  int          rx_snap;

  initial begin
    rst_n = 1'b0;
    bus.cfg_ctrl_i = 32'h0; bus.cfg_valid_i = 1'b0;
    bus.tx_data_i = 8'h0;   bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(bus.wr_en_cpu_o), 32'd0);
    chk("rst_rd", 32'(bus.rd_en_cpu_o), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    chk("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    rst_n = 1'b1;

    // First poll after POLL_GAP idle cycles, then steady poll spacing.
    wait_strobe(1'b0, "poll0", a, d, w);
    chk("poll0_addr", 32'(a), 32'd0);
    chk("poll0_delay", 32'(w), 32'(POLL_GAP));
    wait_strobe(1'b0, "poll1", a, d, w);
    chk("poll_spacing", 32'(w), 32'(POLL_GAP + 2));

    // Configuration write with start bit stripped.
    @(negedge clk);
    bus.cfg_ctrl_i = 32'h4001_0003; bus.cfg_valid_i = 1'b1;
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    wait_strobe(1'b1, "cfg_wr", a, d, w);
    chk("cfg_addr", 32'(a), 32'd1);
    chk("cfg_data", d, 32'h4001_0001);
    wait_strobe(1'b0, "cfg_poll", a, d, w);
    chk("cfg_poll_addr", 32'(a), 32'd0);

    // Transmit 0xA5: TX write then START write.
    bus.tx_data_i = 8'hA5; bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    chk("tx_ready_full", 32'(bus.tx_ready_o), 32'd0);
    wait_strobe(1'b1, "txd_wr", a, d, w);
    chk("txd_addr", 32'(a), 32'd2);
    chk("txd_data", d, 32'h0000_00A5);
    @(negedge clk);
    chk("start_wr", 32'(bus.wr_en_cpu_o), 32'd1);
    chk("start_addr", 32'(bus.cpu_addr_o), 32'd1);
    chk("start_data", bus.cpu_data_o, 32'h4001_0003);
    @(negedge clk);
    chk("tx_ready_free", 32'(bus.tx_ready_o), 32'd1);
    chk("busy_inflight", 32'(bus.busy_o), 32'd1);
    stat_val = 32'h0000_0002;
    wait_strobe(1'b0, "poll_busy", a, d, w);
    @(negedge clk);
    stat_val = 32'h0;
    @(negedge clk);
    chk("busy_hold", 32'(bus.busy_o), 32'd1);
    wait_strobe(1'b0, "poll_idle", a, d, w);
    @(negedge clk);
    @(negedge clk);
    chk("busy_fall", 32'(bus.busy_o), 32'd0);

    // Receive 0x3C with parity error.
    stat_val = 32'h0005_0000; rx_val = 32'hFFFF_FF3C;
    wait_strobe(1'b0, "rx_poll", a, d, w);
    @(negedge clk);
    stat_val = 32'h0;
    wait_strobe(1'b0, "rx_rd", a, d, w);
    chk("rx_rd_addr", 32'(a), 32'd3);
    chk("rx_rd_delay", 32'(w), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rx_valid", 32'(bus.rx_valid_o), 32'd1);
    chk("rx_data", 32'(bus.rx_data_o), 32'h3C);
    chk("rx_err", 32'(bus.rx_err_o), 32'd1);

    // Consumer stalls: rx_done keeps reappearing but no RX reads.
    stat_val = 32'h0009_0000; rx_val = 32'h0000_0055;
    rx_snap = rx_reads;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(1'b0, "held_poll", a, d, w);
      chk("held_poll_addr", 32'(a), 32'd0);
    end
    chk("held_no_rx_read", 32'(rx_reads), 32'(rx_snap));
    chk("held_rx_data", 32'(bus.rx_data_o), 32'h3C);
    @(negedge clk);
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_ready_i = 1'b0;
    chk("rx_popped", 32'(bus.rx_valid_o), 32'd0);
    wait_strobe(1'b0, "rel_poll", a, d, w);
    chk("rel_poll_addr", 32'(a), 32'd0);
    @(negedge clk);
    stat_val = 32'h0;
    wait_strobe(1'b0, "rel_rx_rd", a, d, w);
    chk("rel_rx_addr", 32'(a), 32'd3);
    chk("rel_rx_delay", 32'(w), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rx2_data", 32'(bus.rx_data_o), 32'h55);
    chk("rx2_err", 32'(bus.rx_err_o), 32'd2);
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_ready_i = 1'b0;

    // Config and tx offered together: CTRL write first.
    bus.cfg_ctrl_i = 32'h0000_00F2; bus.cfg_valid_i = 1'b1;
    bus.tx_data_i = 8'h5A; bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.cfg_valid_i = 1'b0; bus.tx_valid_i = 1'b0;
    wait_strobe(1'b1, "both_cfg", a, d, w);
    chk("both_cfg_addr", 32'(a), 32'd1);
    chk("both_cfg_data", d, 32'h0000_00F0);
    wait_strobe(1'b1, "both_txd", a, d, w);
    chk("both_txd_addr", 32'(a), 32'd2);
    chk("both_txd_data", d, 32'h0000_005A);
    @(negedge clk);
    chk("both_start_data", bus.cpu_data_o, 32'h0000_00F2);
    stat_val = 32'h0001_0001; rx_val = 32'h0000_0077;
    wait_strobe(1'b0, "done_poll", a, d, w);
    @(negedge clk);
    wait_strobe(1'b0, "done_rx_rd", a, d, w);
    chk("done_rx_addr", 32'(a), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("done_busy", 32'(bus.busy_o), 32'd0);
    chk("done_rx_data", 32'(bus.rx_data_o), 32'h77);
    chk("done_rx_valid", 32'(bus.rx_valid_o), 32'd1);

    // Reset during the START write.
    bus.tx_data_i = 8'h11; bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    wait_strobe(1'b1, "last_txd", a, d, w);
    chk("last_txd_data", d, 32'h0000_0011);
    @(negedge clk);
    chk("pre_rst_wr", 32'(bus.wr_en_cpu_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(bus.wr_en_cpu_o), 32'd0);
    chk("mid_rst_rd", 32'(bus.rd_en_cpu_o), 32'd0);
    chk("mid_rst_addr", 32'(bus.cpu_addr_o), 32'd0);
    chk("mid_rst_data", bus.cpu_data_o, 32'd0);
    chk("mid_rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    chk("mid_rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    chk("no_overlap", 32'(overlap), 32'd0);
    chk("idle_bus_zero", 32'(junk), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bus_initiator.md
# uart_bus_initiator

Bus-side initiator for the UART register block: it drives the CPU-side write/read/address/data strobes of the UART register interface, so that hardware without a processor can configure the UART, send bytes and collect received bytes. It sits where a CPU bus controller would, one level above the UART register controller. It exposes byte-stream valid/ready ports toward user logic and runs a fixed register-access sequencer with status polling.

## Interface
- CPU_ADDR_WIDTH, 2: register address width.
- CPU_DATA_WIDTH, 32: register data width (≥ 32).
- MAX_UART_DATA_W, 8: UART byte width.
- POLL_GAP, 4: idle cycles between status polls (≥ 1).
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cfg_ctrl_i  in  CPU_DATA_WIDTH  CTRL word to program; bit 1 (start) ignored.
- cfg_valid_i  in  1  one-cycle request to (re)write CTRL with cfg_ctrl_i.
- tx_data_i  in  MAX_UART_DATA_W  byte to transmit.
- tx_valid_i  in  1  tx byte offered.
- tx_ready_o  out  1  tx byte buffer empty.
- rx_data_o  out  MAX_UART_DATA_W  received byte.
- rx_err_o  out  2  {stop_err, parity_err} captured with rx_data_o.
- rx_valid_o  out  1  received byte held.
- rx_ready_i  in  1  consumer accepts byte.
- busy_o  out  1  FSM not in IDLE or tx in flight.
- wr_en_cpu_o  out  1  register write strobe.
- rd_en_cpu_o  out  1  register read strobe.
- cpu_addr_o  out  CPU_ADDR_WIDTH  register address.
- cpu_data_o  out  CPU_DATA_WIDTH  write data.
- cpu_data_i  in  CPU_DATA_WIDTH  read data, valid the cycle after rd_en_cpu_o.

## Operation
- Register map: 0 STAT, 1 CTRL, 2 TX, 3 RX. STAT bits: 0 tx_done, 1 tx_busy, 16 rx_done, 18 parity_err, 19 stop_err. CTRL bit 1 = tx_start. RX[7:0] = data.
- Internal state: cfg_pend, ctrl_shadow (last CTRL written, start bit 0), tx_buf/tx_full, tx_inflight, tx_seen, rx_buf/rx_full, gap counter.
- cfg_valid_i sets cfg_pend and latches cfg_ctrl_i with bit 1 forced 0; a later pulse before service overwrites it.
- tx handshake: byte accepted when tx_valid_i && tx_ready_o; tx_ready_o = !tx_full.
- FSM states: IDLE, WR_CFG, WR_TXD, WR_START, POLL_RD, POLL_CHK, RX_RD, RX_CHK.
- IDLE priority: cfg_pend -> WR_CFG; else tx_full && !tx_inflight -> WR_TXD; else gap counter expired -> POLL_RD; else stay.
- WR_CFG: write CTRL = latched word, update ctrl_shadow, clear cfg_pend -> IDLE.
- WR_TXD: write TX = tx_buf (zero-extended) -> WR_START.
- WR_START: write CTRL = ctrl_shadow | bit 1; clear tx_full, set tx_inflight, clear tx_seen -> IDLE.
- POLL_RD: read STAT -> POLL_CHK. POLL_CHK samples cpu_data_i: if tx_inflight: tx_done=1 or (tx_seen and tx_busy=0) clears tx_inflight; else tx_busy=1 sets tx_seen. Then if rx_done=1 and !rx_full -> RX_RD (latch err bits), else reload gap counter -> IDLE.
- RX_RD: read RX -> RX_CHK; RX_CHK latches cpu_data_i[7:0] into rx_buf, sets rx_full -> IDLE with gap reload.
- rx_valid_o = rx_full; cleared on rx_valid_o && rx_ready_i. While rx_full, rx_done is ignored (byte left pending, re-seen on later polls).
- Start bit clearing in CTRL is done by the register side; this block never writes CTRL with bit 1 except in WR_START.

## Timing
- Reset (async assert, sync release): all outputs 0 except tx_ready_o=1; state IDLE; gap counter = POLL_GAP; all flags clear.
- Every bus access is exactly one cycle strobe; wr_en_cpu_o and rd_en_cpu_o never both high; address/data valid only with strobe, else 0.
- Read data sampled exactly one cycle after rd_en_cpu_o (POLL_CHK/RX_CHK).
- Tx byte to TX write: 2 cycles min (accept, IDLE, WR_TXD); START write next cycle.
- Gap counter decrements in IDLE only; poll issued when it reaches 0.
- Simultaneous tx accept and rx pop in same cycle: both honoured.
- New byte accepted while tx_inflight; it waits until tx_inflight clears.
- Reset mid-sequence: strobes drop asynchronously; buffered bytes discarded.

## Test plan
- Reset with rst_ni=0 mid-WR_START -> all strobes 0 immediately, tx_ready_o=1, rx_valid_o=0, busy_o=0.
- cfg_valid_i with cfg_ctrl_i=0x4001_0003 -> single write addr 1 data 0x4001_0001; next STAT poll after POLL_GAP idle cycles.
- Offer tx 0xA5 -> write addr 2 data 0x0000_00A5, next cycle write addr 1 data ctrl_shadow|0x2; STAT returns busy=1 then 0 -> tx_inflight clears, busy_o falls.
- STAT returns 0x0004_0000|0x1_0000 (rx_done, parity_err), RX returns 0x3C -> rx_data_o=0x3C, rx_err_o=2'b01, rx_valid_o=1.
- rx_ready_i held 0 with rx_done repeatedly set -> no RX reads issued, rx_data_o stable; raise rx_ready_i -> next poll reads RX.
- cfg_valid_i and tx_valid_i same cycle -> CTRL config write precedes TX write; no overlapping strobes.
